// File: rtl/zbt_pixel_packer.sv
// Packs pairs of horizontally adjacent RGB888 pixels into 36-bit RGB666 ZBT words and queues them.
// Optional PACKER_TESTPAT_EN adds a testpat input that substitutes a coordinate-derived pattern.
module zbt_pixel_packer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  input  logic [10:0] pix_hcount,
  input  logic [9:0]  pix_vcount,
`ifdef PACKER_TESTPAT_EN
  input  logic        testpat,
`endif
  input  logic        wr_grant,
  output logic        wr_valid,
  output logic [18:0] wr_addr,
  output logic [35:0] wr_data,
  output logic        pair_err,
  output logic        overflow,
  output logic        dbg_state_odd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

  typedef enum logic {ST_EVEN = 1'b0, ST_ODD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [17:0]   half_q, half_d;
  logic [18:0]   tag_q, tag_d;
  logic          pair_err_q, pair_err_d;
  logic          overflow_q, overflow_d;
  logic [54:0]   mem_q [FIFO_DEPTH];
  logic [54:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        accepted, push, push_ok, pop, full;
  logic [23:0] pix_src;
  logic [17:0] half_new;
  logic [18:0] tag_new;
  logic [54:0] head;

`ifdef PACKER_TESTPAT_EN
  assign pix_src = testpat ? {pix_hcount[7:0], pix_vcount[7:0], pix_hcount[7:0] ^ pix_vcount[7:0]}
                           : pix_data;
`else
  assign pix_src = pix_data;
`endif

  assign accepted = pix_valid && (pix_hcount < H_LIM) && (pix_vcount < V_LIM);
  assign half_new = {pix_src[23:18], pix_src[15:10], pix_src[7:2]};
  assign tag_new  = {pix_vcount, pix_hcount[9:1]};
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign wr_valid = (count_q != '0);
  assign pop      = wr_valid && wr_grant;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop);
  assign head     = mem_q[rd_ptr_q];

  assign wr_addr       = head[54:36];
  assign wr_data       = head[35:0];
  assign pair_err      = pair_err_q;
  assign overflow      = overflow_q;
  assign dbg_state_odd = (state_q == ST_ODD);

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    tag_d      = tag_q;
    pair_err_d = pair_err_q;
    push       = 1'b0;
    if (accepted) begin
      unique case (state_q)
        ST_EVEN: begin
          if (!pix_hcount[0]) begin
            half_d  = half_new;
            tag_d   = tag_new;
            state_d = ST_ODD;
          end else begin
            pair_err_d = 1'b1;
          end
        end
        ST_ODD: begin
          if (pix_hcount[0]) begin
            if (tag_new == tag_q) push = 1'b1;
            else                  pair_err_d = 1'b1;
            state_d = ST_EVEN;
          end else begin
            pair_err_d = 1'b1;
            half_d     = half_new;
            tag_d      = tag_new;
          end
        end
        default: state_d = ST_EVEN;
      endcase
    end
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {tag_q, half_q, half_new};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (push && full && !pop) overflow_d = 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EVEN;
      half_q     <= '0;
      tag_q      <= '0;
      pair_err_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      tag_q      <= tag_d;
      pair_err_q <= pair_err_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_zbt_pixel_packer.sv
// Directed bench for zbt_pixel_packer: expected words queued as pairs are driven, checked as they leave.
module tb_zbt_pixel_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = '0;
  logic [10:0] pix_hcount = '0;
  logic [9:0]  pix_vcount = '0;
  logic        testpat = 1'b0;
  logic        wr_grant = 1'b0;
  logic        wr_valid, pair_err, overflow, dbg_state_odd;
  logic [18:0] wr_addr;
  logic [35:0] wr_data;

  logic [54:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  zbt_pixel_packer dut (
    .clock(clock), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_hcount(pix_hcount), .pix_vcount(pix_vcount),
`ifdef PACKER_TESTPAT_EN
    .testpat(testpat),
`endif
    .wr_grant(wr_grant), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .pair_err(pair_err), .overflow(overflow), .dbg_state_odd(dbg_state_odd)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] reduce(input logic [23:0] d);
    return {d[23:18], d[15:10], d[7:2]};
  endfunction

  function automatic logic [54:0] word(input int x, input int y, input logic [23:0] de,
                                       input logic [23:0] dodd);
    logic [10:0] xb;
    logic [9:0]  yb;
    xb = 11'(x);
    yb = 10'(y);
    return {yb, xb[9:1], reduce(de), reduce(dodd)};
  endfunction

  // Called at posedge+1; drives one pixel for one clock and returns at the next posedge+1.
  task automatic send(input int x, input int y, input logic [23:0] d);
    pix_valid  = 1'b1;
    pix_hcount = 11'(x);
    pix_vcount = 10'(y);
    pix_data   = d;
    @(posedge clock); #1;
    pix_valid  = 1'b0;
  endtask

  task automatic send_pair(input int x, input int y, input bit expect_push);
    logic [23:0] de, dodd;
    de   = 24'($urandom);
    dodd = 24'($urandom);
    send(x, y, de);
    if (expect_push) exp_q.push_back(word(x, y, de, dodd));
    send(x + 1, y, dodd);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Words leave when the head is valid and granted; sample mid-cycle.
  always @(negedge clock) begin
    if (!reset && wr_valid && wr_grant) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {9'd0, wr_addr, wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("word", {9'd0, wr_addr, wr_data}, {9'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [23:0] d6, d7, tp2, tp3;
    #2;
    check("rst_wr_valid", 64'(wr_valid), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_pair_err", 64'(pair_err), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    wr_grant = 1'b1;

    // single pair with known colours and one-cycle latency
    send(0, 5, 24'hFC0000);
    check("t1_no_early_valid", 64'(wr_valid), 64'd0);
    exp_q.push_back({10'd5, 9'd0, 18'h3F000, 18'h00FC0});
    send(1, 5, 24'h00FC00);
    check("t1_latency_valid", 64'(wr_valid), 64'd1);
    idle(3);

    // full active line
    for (int x = 0; x < 640; x += 2) send_pair(x, 0, 1'b1);
    idle(3);
    check("t2_pair_err", 64'(pair_err), 64'd0);
    check("t2_overflow", 64'(overflow), 64'd0);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // out-of-area pixels leave state untouched
    d6 = 24'h123456;
    d7 = 24'hABCDEF;
    send(10, 7, d6);
    send(640, 7, 24'hFFFFFF);
    send(641, 7, 24'hFFFFFF);
    send(11, 480, 24'hFFFFFF);
    check("t5_no_write", 64'(wr_valid), 64'd0);
    check("t5_still_odd", 64'(dbg_state_odd), 64'd1);
    exp_q.push_back(word(10, 7, d6, d7));
    send(11, 7, d7);
    idle(3);
    check("t5_pair_err", 64'(pair_err), 64'd0);

    // queue fill and overflow
    wr_grant = 1'b0;
    for (int p = 0; p < 5; p++) send_pair(100 + 2 * p, 3, p < 4);
    check("t3_valid_held", 64'(wr_valid), 64'd1);
    check("t3_overflow", 64'(overflow), 64'd1);
    wr_grant = 1'b1;
    idle(6);
    check("t3_valid_fell", 64'(wr_valid), 64'd0);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // pairing errors
    send(3, 9, 24'h010101);
    check("t4_lone_odd", 64'(pair_err), 64'd1);
    send(4, 9, 24'h020202);
    d6 = 24'h80C0E0;
    d7 = 24'h40A0F0;
    send(6, 9, d6);
    exp_q.push_back(word(6, 9, d6, d7));
    send(7, 9, d7);
    idle(3);
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // asynchronous reset with words and a half pending
    wr_grant = 1'b0;
    send_pair(20, 11, 1'b1);
    send_pair(22, 11, 1'b1);
    send(24, 11, 24'h777777);
    check("t6_held", 64'(wr_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", 64'(wr_valid), 64'd0);
    check("t6_async_addr", 64'(wr_addr), 64'd0);
    check("t6_async_perr", 64'(pair_err), 64'd0);
    check("t6_async_ovf", 64'(overflow), 64'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    wr_grant = 1'b1;
    send(1, 0, 24'h555555);
    check("t6_half_discarded", 64'(pair_err), 64'd1);
    check("t6_no_word", 64'(wr_valid), 64'd0);

`ifdef PACKER_TESTPAT_EN
    testpat = 1'b1;
    tp2 = {8'h02, 8'h01, 8'h03};
    tp3 = {8'h03, 8'h01, 8'h02};
    send(2, 1, 24'hFFFFFF);
    exp_q.push_back(word(2, 1, tp2, tp3));
    send(3, 1, 24'hFFFFFF);
    testpat = 1'b0;
    idle(3);
    check("tp_drained", 64'(exp_q.size()), 64'd0);
`else
    tp2 = '0;
    tp3 = '0;
`endif

    idle(4);
    check("end_empty", 64'(exp_q.size()), 64'd0);
    check("end_valid", 64'(wr_valid), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
